// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter.
package counter_pkg;

    // Default counter width in bits.
    localparam int COUNTER_W = 4;

endpackage : counter_pkg

// File: rtl/counter.sv
// Up/down event counter with independent increment and decrement strobes.
// The count moves by at most one per clock. At the limits it either wraps
// modulo 2**WIDTH or saturates, depending on WRAP.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_W,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,   // asynchronous, active-low
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = '0;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step up or down on a lone strobe; hold when both or neither
    // strobe is set. With WRAP clear, hold at the limit instead of rolling over.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (WRAP || (count_q != MAX_VAL)) begin
                count_d = count_q + ONE;
            end
        end else if (dec && !inc) begin
            if (WRAP || (count_q != MIN_VAL)) begin
                count_d = count_q - ONE;
            end
        end
    end

    // Count register. Reset clears it at once, without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : counter

// File: tb/tb_counter.sv
// Self-checking bench for the counter. Two instances share the stimulus:
// one built to wrap and one built to saturate.
`timescale 1ns/1ps
module tb_counter;

    localparam int W   = 4;
    localparam int LIM = 16;   // 2**W

    logic         clk = 1'b0;
    logic         rst;
    logic         inc;
    logic         dec;
    logic [W-1:0] count_w;
    logic [W-1:0] count_s;

    int total = 0;
    int bad   = 0;

    int m_w = 0;   // expected count for the wrapping instance
    int m_s = 0;   // expected count for the saturating instance

    counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .count (count_w)
    );

    counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .count (count_s)
    );

    always #5 clk = ~clk;

    // Expected count after one clock, from the rules in arithmetic terms.
    function automatic int next_val(int cur, logic i, logic d, bit wrap);
        int delta;
        int v;
        delta = (i && !d) ? 1 : ((d && !i) ? -1 : 0);
        v = cur + delta;
        if (wrap) begin
            v = (v + LIM) % LIM;
        end else begin
            if (v < 0) v = 0;
            if (v > LIM - 1) v = LIM - 1;
        end
        return v;
    endfunction

    // Reference model: reset empties it immediately, otherwise one step per edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_w = 0;
            m_s = 0;
        end else begin
            m_w = next_val(m_w, inc, dec, 1'b1);
            m_s = next_val(m_s, inc, dec, 1'b0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        total++;
        if (int'(count_w) != m_w) begin
            bad++;
            $display("FAIL model_wrap t=%0t got=%0d expected=%0d", $time, count_w, m_w);
        end
        total++;
        if (int'(count_s) != m_s) begin
            bad++;
            $display("FAIL model_sat t=%0t got=%0d expected=%0d", $time, count_s, m_s);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input int exp_v);
        total++;
        if (int'(got) != exp_v) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
        end else begin
            $display("ok   %s count=%0d", name, got);
        end
    endtask

    // Apply one strobe pattern for n clocks; returns 1ns after the last edge.
    task automatic step(input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            inc = i;
            dec = d;
            @(posedge clk);
            #1;
        end
    endtask

    // Short reset pulse inside the low phase of the clock.
    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        inc = 1'b0;
        dec = 1'b0;
        #1 rst = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        inc = 1'b0;
        dec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wrap", count_w, 0);
        chk("reset_sat",  count_s, 0);

        // Release reset; idle clocks keep the count at zero.
        @(negedge clk);
        #1 rst = 1'b1;
        step(1'b0, 1'b0, 2);
        chk("release_idle", count_w, 0);

        // Increment twice, decrement once, then hold.
        step(1'b1, 1'b0, 2);
        chk("inc2", count_w, 2);
        step(1'b0, 1'b1, 1);
        chk("dec1", count_w, 1);
        step(1'b0, 1'b0, 2);
        chk("hold", count_w, 1);

        // Mid-cycle reset assertion clears at once, no edge needed.
        #2 rst = 1'b0;
        #1;
        chk("async_clear_wrap", count_w, 0);
        chk("async_clear_sat",  count_s, 0);
        @(negedge clk);
        #1 rst = 1'b1;

        // Both strobes together hold the count.
        step(1'b1, 1'b0, 5);
        chk("reach5", count_w, 5);
        step(1'b1, 1'b1, 3);
        chk("both_hold_wrap", count_w, 5);
        chk("both_hold_sat",  count_s, 5);

        // Upper limit: wrap to 0 versus hold at 15.
        step(1'b1, 1'b0, 10);
        chk("reach15", count_w, 15);
        step(1'b1, 1'b0, 1);
        chk("top_wrap", count_w, 0);
        chk("top_sat",  count_s, 15);

        // Lower limit: wrap to 15 versus hold at 0.
        pulse_reset();
        step(1'b0, 1'b1, 1);
        chk("bottom_wrap", count_w, 15);
        chk("bottom_sat",  count_s, 0);

        // Saturation held over several cycles at each limit.
        pulse_reset();
        step(1'b1, 1'b0, 15);
        step(1'b1, 1'b0, 3);
        chk("sat_top3_sat",  count_s, 15);
        chk("sat_top3_wrap", count_w, 2);
        pulse_reset();
        step(1'b0, 1'b1, 3);
        chk("sat_bot3_sat",  count_s, 0);
        chk("sat_bot3_wrap", count_w, 13);

        // Reset between edges while incrementing from 9.
        pulse_reset();
        step(1'b1, 1'b0, 9);
        chk("reach9", count_w, 9);
        @(negedge clk);
        inc = 1'b1;
        dec = 1'b0;
        @(posedge clk);
        #1;
        chk("count10", count_w, 10);
        #2 rst = 1'b0;
        #1;
        chk("midcount_clear", count_w, 0);
        @(posedge clk);
        #1;
        chk("reset_overrides_inc", count_w, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        inc = 1'b0;
        step(1'b0, 1'b0, 2);
        chk("final_idle", count_w, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_counter
